rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Clocked front end that shares one asynchronous ROM (byte-wide, active-low chip select and output enable) between two requesters, e.g. instruction fetch (port 0) and a loader/display fetch (port 1).
- Registers the address and drives the ROM control strobes.
- Holds the strobes for a programmable number of wait states to cover ROM access plus output-driver delay, then latches the byte into a per-requester data register and pulses an acknowledge.
- Arbitration between the two requesters is round-robin.

Parameters:
- ADDR_WIDTH, 15: ROM address width.
- WAIT_STATES, 2: extra clocks the strobes are held before the data is latched. Legal range is 0..15.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ0  input  1  requester 0 read request, level-sensitive.
- ADDR0  input  ADDR_WIDTH  requester 0 address.
- ACK0  output  1  one-cycle pulse: DATA0 has been updated.
- DATA0  output  8  last byte read for requester 0.
- REQ1  input  1  requester 1 read request.
- ADDR1  input  ADDR_WIDTH  requester 1 address.
- ACK1  output  1  one-cycle pulse: DATA1 has been updated.
- DATA1  output  8  last byte read for requester 1.
- ROM_A  output  ADDR_WIDTH  registered ROM address.
- ROM_CS_bar  output  1  ROM chip select, active low.
- ROM_OE_bar  output  1  ROM output enable, active low.
- ROM_WE_bar  output  1  tied high at all times.
- ROM_Q  input  8  ROM data bus.
- BUSY  output  1  high whenever the state is not IDLE.

Behaviour:
- **Reset** (RST high at an edge, from any state, including mid-access):
  - state = IDLE
  - ROM_CS_bar = ROM_OE_bar = 1, ROM_A = 0
  - ACK0 = ACK1 = 0, DATA0 = DATA1 = 0, BUSY = 0
  - LAST = 1 (internal last-grant register), so requester 0 wins the first tie
  - No ACK is ever produced for an access that reset aborts.
- **States:** IDLE, ACCESS, DONE. All outputs are registered.
- **IDLE** (edge k):
  - No request: stay in IDLE.
  - Exactly one REQn high: grant n.
  - Both high: grant the requester not equal to LAST.
  - On grant: ROM_A <= ADDRn, ROM_CS_bar <= 0, ROM_OE_bar <= 0, GNT <= n, LAST <= n, CNT <= WAIT_STATES, go to ACCESS.
- **ACCESS:**
  - CNT != 0: CNT <= CNT - 1, strobes and ROM_A held.
  - CNT == 0:
    - DATAn <= ROM_Q, ACKn <= 1
    - ROM_CS_bar <= 1, ROM_OE_bar <= 1
    - go to DONE.
- **DONE:** ACKn <= 0, go to IDLE. This gives one bus-turnaround cycle with strobes high.
- **Timing:**
  - Strobes are low for exactly WAIT_STATES+1 cycles.
  - ACK rises at edge k+WAIT_STATES+1.
  - The next grant occurs no earlier than edge k+WAIT_STATES+3, i.e. a throughput of one access per WAIT_STATES+3 clocks.
- **Requester rules:**
  - ADDRn is sampled only at the grant edge; later changes are ignored.
  - Dropping REQn after the grant does not cancel the access: the ACK still fires.
  - A requester drops REQ on seeing ACK. A REQ still high in IDLE starts a new access.
- **Fairness:** with both requests held continuously, grants strictly alternate 0, 1, 0, 1, …
- **Data registers:**
  - DATAn changes only on the ACKn edge.
  - DATAn holds its value indefinitely otherwise, and is unaffected by accesses for the other requester.
- **Exclusivity:** at most one of ACK0/ACK1 is high in any cycle. ROM_WE_bar is never 0.
- **WAIT_STATES = 0:** the ACCESS state lasts one cycle.
- **Counter width:** 4 bits.

Test Plan:
1. **Reset values.** Drive RST high for 2 cycles with REQ0 = 1 → all outputs at their reset values. Release RST → grant on the first IDLE edge with ROM_A = ADDR0.
2. **Single read, WAIT_STATES=2.**
   - Stimulus: ROM model with 2-cycle read delay, byte 0x0123 = 0xA5; REQ0 = 1, ADDR0 = 0x0123.
   - Response: CS/OE low for exactly 3 cycles; ACK0 high for 1 cycle, 3 edges after the grant; DATA0 = 0xA5; DATA1 stays 0.
3. **Simultaneous requests after reset.**
   - Stimulus: REQ0 and REQ1 both held, ADDR0 = 0x0010 (0x11), ADDR1 = 0x0020 (0x22).
   - Response: grant order 0, 1, 0, 1; ACK0/ACK1 alternate and never overlap; DATA0 = 0x11, DATA1 = 0x22; 5 clocks between successive ACKs.
4. **Address change and early REQ drop.** Change ADDR0 from 0x0001 to 0x0002 and drop REQ0 one cycle after the grant → ROM_A stays 0x0001; ACK0 still fires; DATA0 = byte at 0x0001; no second access.
5. **Reset mid-access.** Assert RST while in ACCESS with CNT = 1 → strobes high next edge; no ACK ever appears; DATA registers = 0; BUSY = 0.
6. **WAIT_STATES=0, back-to-back.** Hold REQ1 continuously with ADDR1 stepping 0..3 on each ACK → strobes low for 1 cycle per access; ACK1 every 3 clocks; DATA1 follows ROM contents 0..3 in order.

Source files
------------

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arbiter
//  Description : Clocked front end sharing one asynchronous byte-wide ROM
//                between two requesters with round-robin arbitration.
//                The ROM address is registered and the active-low strobes
//                are driven for WAIT_STATES+1 clocks. The byte is then
//                latched into the granted requester's data register, and a
//                one-cycle acknowledge is pulsed. One turnaround cycle with
//                the strobes high follows every access.
//  Ports       : CLK/RST            clock, synchronous active-high reset
//                REQn/ADDRn         level request and address, port n
//                ACKn/DATAn         one-cycle ack and last byte, port n
//                ROM_A/ROM_CS_bar/ROM_OE_bar/ROM_WE_bar/ROM_Q  ROM bus
//                BUSY               high whenever not idle
//  Revision    : 1.0  initial release
// ============================================================================
module rom_arbiter #(
    parameter int ADDR_WIDTH  = 15,
    parameter int WAIT_STATES = 2     // legal range 0..15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    output logic                  ACK0,
    output logic [7:0]            DATA0,
    input  logic                  REQ1,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    output logic                  ACK1,
    output logic [7:0]            DATA1,
    output logic [ADDR_WIDTH-1:0] ROM_A,
    output logic                  ROM_CS_bar,
    output logic                  ROM_OE_bar,
    output logic                  ROM_WE_bar,
    input  logic [7:0]            ROM_Q,
    output logic                  BUSY
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;
    localparam logic [3:0] c_WAIT      = 4'(WAIT_STATES);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_gnt;
    logic                  r_last;
    logic [ADDR_WIDTH-1:0] r_rom_a;
    logic                  r_cs_n;
    logic                  r_oe_n;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [7:0]            r_data0;
    logic [7:0]            r_data1;

    logic                  w_req_any;
    logic                  w_sel;

    assign w_req_any = REQ0 | REQ1;
    // On a tie the requester that did not win last time gets the bus;
    // otherwise whichever requester is asking wins.
    assign w_sel     = (REQ0 & REQ1) ? ~r_last : REQ1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;      // requester 0 wins the first tie
            r_rom_a <= '0;
            r_cs_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_data0 <= 8'd0;
            r_data1 <= 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req_any) begin
                        r_gnt   <= w_sel;
                        r_last  <= w_sel;
                        r_rom_a <= w_sel ? ADDR1 : ADDR0;
                        r_cs_n  <= 1'b0;
                        r_oe_n  <= 1'b0;
                        r_cnt   <= c_WAIT;
                        r_state <= c_ST_ACCESS;
                    end
                end
                c_ST_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (r_gnt) begin
                            r_data1 <= ROM_Q;
                            r_ack1  <= 1'b1;
                        end else begin
                            r_data0 <= ROM_Q;
                            r_ack0  <= 1'b1;
                        end
                        r_cs_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    // Turnaround cycle: strobes already high, ack ends here.
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ACK0       = r_ack0;
    assign ACK1       = r_ack1;
    assign DATA0      = r_data0;
    assign DATA1      = r_data1;
    assign ROM_A      = r_rom_a;
    assign ROM_CS_bar = r_cs_n;
    assign ROM_OE_bar = r_oe_n;
    assign ROM_WE_bar = 1'b1;
    assign BUSY       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_arbiter
//  Description : Directed self-checking bench for rom_arbiter. Instance a
//                uses WAIT_STATES=2 with a two-cycle ROM model; instance b
//                uses WAIT_STATES=0 with a combinational ROM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rom_arbiter;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst;

    // instance a (WAIT_STATES = 2)
    logic          a_req0, a_req1, a_ack0, a_ack1;
    logic [AW-1:0] a_addr0, a_addr1, a_rom_a;
    logic [7:0]    a_data0, a_data1, a_rom_q;
    logic          a_cs_n, a_oe_n, a_we_n, a_busy;
    logic [7:0]    r_d1, r_d2;

    // instance b (WAIT_STATES = 0)
    logic          b_req0, b_req1, b_ack0, b_ack1;
    logic [AW-1:0] b_addr0, b_addr1, b_rom_a;
    logic [7:0]    b_data0, b_data1, b_rom_q;
    logic          b_cs_n, b_oe_n, b_we_n, b_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rom_arbiter #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) u_dut_a (
        .CLK(clk), .RST(rst),
        .REQ0(a_req0), .ADDR0(a_addr0), .ACK0(a_ack0), .DATA0(a_data0),
        .REQ1(a_req1), .ADDR1(a_addr1), .ACK1(a_ack1), .DATA1(a_data1),
        .ROM_A(a_rom_a), .ROM_CS_bar(a_cs_n), .ROM_OE_bar(a_oe_n),
        .ROM_WE_bar(a_we_n), .ROM_Q(a_rom_q), .BUSY(a_busy)
    );

    rom_arbiter #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut_b (
        .CLK(clk), .RST(rst),
        .REQ0(b_req0), .ADDR0(b_addr0), .ACK0(b_ack0), .DATA0(b_data0),
        .REQ1(b_req1), .ADDR1(b_addr1), .ACK1(b_ack1), .DATA1(b_data1),
        .ROM_A(b_rom_a), .ROM_CS_bar(b_cs_n), .ROM_OE_bar(b_oe_n),
        .ROM_WE_bar(b_we_n), .ROM_Q(b_rom_q), .BUSY(b_busy)
    );

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        case (a)
            15'h0123: rom_byte = 8'hA5;
            15'h0010: rom_byte = 8'h11;
            15'h0020: rom_byte = 8'h22;
            15'h0001: rom_byte = 8'h5A;
            15'h0002: rom_byte = 8'hC3;
            default:  rom_byte = a[7:0] ^ 8'h3C;
        endcase
    endfunction

    // ROM a: data valid two clocks after the address settles.
    always @(posedge clk) begin
        r_d1 <= rom_byte(a_rom_a);
        r_d2 <= r_d1;
    end
    assign a_rom_q = (!a_cs_n && !a_oe_n) ? r_d2 : 8'hFF;
    // ROM b: contents equal the low address byte, no delay.
    assign b_rom_q = (!b_cs_n && !b_oe_n) ? b_rom_a[7:0] : 8'hFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_cs"},   32'(a_cs_n), 32'd1);
        check({tag, "_oe"},   32'(a_oe_n), 32'd1);
        check({tag, "_a"},    32'(a_rom_a), 32'd0);
        check({tag, "_ack"},  32'({a_ack0, a_ack1}), 32'd0);
        check({tag, "_d0"},   32'(a_data0), 32'd0);
        check({tag, "_d1"},   32'(a_data1), 32'd0);
        check({tag, "_busy"}, 32'(a_busy), 32'd0);
    endtask

    initial begin
        int n;
        int last_cyc;
        int lowcnt;
        logic seen;

        rst = 1'b1;
        a_req0 = 1'b1; a_addr0 = 15'h0123; a_req1 = 1'b0; a_addr1 = '0;
        b_req0 = 1'b0; b_addr0 = '0;       b_req1 = 1'b0; b_addr1 = '0;

        // 1. reset held two cycles with a pending request
        step();
        check_reset_a("t1_rst1");
        step();
        check_reset_a("t1_rst2");
        check("t1_we", 32'(a_we_n), 32'd1);
        rst = 1'b0;

        // 2. single read: grant on the first idle edge
        step();
        check("t2_grant_a",  32'(a_rom_a), 32'h0123);
        check("t2_grant_cs", 32'({a_cs_n, a_oe_n}), 32'd0);
        check("t2_busy",     32'(a_busy), 32'd1);
        step();
        check("t2_k1_cs",  32'({a_cs_n, a_oe_n, a_ack0}), 32'd0);
        step();
        check("t2_k2_cs",  32'({a_cs_n, a_oe_n, a_ack0}), 32'd0);
        step();
        check("t2_k3_cs",   32'({a_cs_n, a_oe_n}), 32'b11);
        check("t2_k3_ack0", 32'(a_ack0), 32'd1);
        check("t2_k3_d0",   32'(a_data0), 32'hA5);
        check("t2_k3_d1",   32'(a_data1), 32'd0);
        a_req0 = 1'b0;
        step();
        check("t2_k4_ack0", 32'(a_ack0), 32'd0);
        check("t2_k4_d0",   32'(a_data0), 32'hA5);
        step();
        check("t2_k5_busy", 32'(a_busy), 32'd0);

        // 3. simultaneous requests after reset: 0,1,0,1 with 5-clock spacing
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_req0 = 1'b1; a_addr0 = 15'h0010;
        a_req1 = 1'b1; a_addr1 = 15'h0020;
        n = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            step();
            if (a_ack0 || a_ack1) begin
                check("t3_overlap", 32'(a_ack0 & a_ack1), 32'd0);
                check("t3_port",    32'(a_ack1), 32'(n % 2));
                if (a_ack1) check("t3_d1", 32'(a_data1), 32'h22);
                else        check("t3_d0", 32'(a_data0), 32'h11);
                if (n > 0) check("t3_gap", 32'(cyc - last_cyc), 32'd5);
                last_cyc = cyc;
                n++;
                if (n == 4) begin
                    a_req0 = 1'b0;
                    a_req1 = 1'b0;
                end
            end
        end
        check("t3_count", 32'(n), 32'd4);
        check("t3_final", 32'({a_data0, a_data1}), 32'h1122);
        step();
        step();
        check("t3_idle", 32'(a_busy), 32'd0);

        // 4. address change and early REQ drop after the grant
        a_req0 = 1'b1; a_addr0 = 15'h0001;
        step();
        check("t4_grant_a", 32'(a_rom_a), 32'h0001);
        a_addr0 = 15'h0002;
        a_req0  = 1'b0;
        step();
        check("t4_hold1", 32'(a_rom_a), 32'h0001);
        step();
        check("t4_hold2", 32'(a_rom_a), 32'h0001);
        step();
        check("t4_ack0", 32'(a_ack0), 32'd1);
        check("t4_d0",   32'(a_data0), 32'h5A);
        step();
        step();
        step();
        check("t4_no_second", 32'({a_busy, a_cs_n}), 32'b01);
        check("t4_keep_a",    32'(a_rom_a), 32'h0001);

        // 5. reset while in ACCESS with the counter at 1
        a_req1 = 1'b1; a_addr1 = 15'h0020;
        step();
        check("t5_grant_a", 32'(a_rom_a), 32'h0020);
        step();
        rst = 1'b1;
        step();
        check_reset_a("t5_rst");
        rst = 1'b0;
        a_req1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | a_ack0 | a_ack1;
        end
        check("t5_no_ack", 32'(seen), 32'd0);
        check("t5_data",   32'({a_data0, a_data1}), 32'd0);

        // 6. WAIT_STATES=0, back-to-back requester 1 accesses
        b_req1 = 1'b1; b_addr1 = 15'd0;
        n = 0; last_cyc = 0; lowcnt = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            step();
            if (!b_cs_n) lowcnt++;
            if (b_ack1) begin
                check("t6_d1",     32'(b_data1), 32'(n));
                check("t6_strobe", 32'(lowcnt), 32'd1);
                check("t6_ack0",   32'(b_ack0), 32'd0);
                if (n > 0) check("t6_gap", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                lowcnt = 0;
                n++;
                b_addr1 = 15'(n);
                if (n == 4) b_req1 = 1'b0;
            end
        end
        check("t6_count", 32'(n), 32'd4);
        check("t6_we",    32'(b_we_n & a_we_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
